// File: rtl/alu_result_capture.sv
// rtl/alu_result_capture.sv - capture stage for the registered adder: tags, flags, 2-entry result buffer
//
// Tracks every add the controller issues through a LAT-deep tag pipe. When a
// tag leaves the pipe, the stage captures the adder's registered sum/c_out,
// derives the Z/N/C/V flags and writes the result to a 2-entry FIFO. The FIFO
// head is returned to the datapath over a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   start      in   operands presented to the adder this cycle (issue)
//   a_msb      in   operand a[W-1], sampled with start
//   b_msb      in   operand b[W-1], sampled with start
//   sum        in   registered adder sum (W bits)
//   c_out      in   registered adder carry out
//   busy       out  issue not accepted this cycle (no buffer credit)
//   res_valid  out  head result valid
//   res_ready  in   consumer takes the head result this cycle
//   res_data   out  head result sum (W bits)
//   flag_z     out  head result == 0
//   flag_n     out  head result sign bit
//   flag_c     out  head carry out
//   flag_v     out  head signed overflow
//   issue_err  out  sticky: start seen while busy

module alu_result_capture #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [W-1:0] sum,
    input  logic         c_out,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         issue_err
);

    // State encoding doubles as the buffered-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [W-1:0] data;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } entry_t;

    buf_state_e   state_q, state_d;
    entry_t       head_q, head_d;
    entry_t       tail_q, tail_d;
    entry_t       cap_entry;

    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] ta_q, ta_d;
    logic [LAT-1:0] tb_q, tb_d;
    logic           issue_err_q, issue_err_d;

    logic           issue;
    logic           cap;
    logic           pop;
    logic           tag_a;
    logic           tag_b;
    logic [31:0]    used;

    // Credits owed = buffered entries plus adds still travelling the pipe.
    always_comb begin
        used = {30'd0, state_q};
        for (int i = 0; i < LAT; i++) begin
            used = used + {31'd0, vld_q[i]};
        end
    end

    assign busy  = (used >= 32'd2);
    assign issue = start & ~busy;

    // Tag pipe: bit 0 is the newest issue, bit LAT-1 leaves this cycle.
    always_comb begin
        vld_d = (vld_q << 1) | LAT'(issue);
        ta_d  = (ta_q << 1) | LAT'(a_msb);
        tb_d  = (tb_q << 1) | LAT'(b_msb);
    end

    assign cap   = vld_q[LAT-1];
    assign tag_a = ta_q[LAT-1];
    assign tag_b = tb_q[LAT-1];

    // Flags are frozen at capture so the buffer holds complete results.
    always_comb begin
        cap_entry.data = sum;
        cap_entry.z    = (sum == '0);
        cap_entry.n    = sum[W-1];
        cap_entry.c    = c_out;
        cap_entry.v    = (tag_a == tag_b) && (sum[W-1] != tag_a);
    end

    assign res_valid = (state_q != EMPTY);
    assign pop       = res_valid & res_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (cap) begin
                    head_d  = cap_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (cap && pop) begin
                    head_d = cap_entry;
                end else if (cap) begin
                    tail_d  = cap_entry;
                    state_d = FULL;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Credits keep capture away from FULL; only a pop moves us.
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign issue_err_d = issue_err_q | (start & busy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            vld_q       <= '0;
            ta_q        <= '0;
            tb_q        <= '0;
            issue_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            vld_q       <= vld_d;
            ta_q        <= ta_d;
            tb_q        <= tb_d;
            issue_err_q <= issue_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(cap && (state_q == FULL)));
        end
    end

    assign res_data  = head_q.data;
    assign flag_z    = head_q.z;
    assign flag_n    = head_q.n;
    assign flag_c    = head_q.c;
    assign flag_v    = head_q.v;
    assign issue_err = issue_err_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// tb/tb_alu_result_capture.sv - scoreboard bench for alu_result_capture

module tb_alu_result_capture;

    localparam int W   = 32;
    localparam int LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         a_msb = 1'b0;
    logic         b_msb = 1'b0;
    logic [W-1:0] sum = '0;
    logic         c_out = 1'b0;
    logic         busy;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         flag_z, flag_n, flag_c, flag_v;
    logic         issue_err;

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } res_t;

    res_t         q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           n_pop = 0;
    bit           err_m = 1'b0;
    logic [W-1:0] pend_sum = '0;
    logic         pend_c = 1'b0;

    alu_result_capture #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .issue_err (issue_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: a handshake at the coming edge pops and compares the head.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && res_valid && res_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got data=%h want no result", res_data);
            end else begin
                e = q.pop_front();
                n_pop++;
                if ({res_data, flag_z, flag_n, flag_c, flag_v} !== {e.d, e.z, e.n, e.c, e.v}) begin
                    n_bad++;
                    $display("FAIL result got data=%h zncv=%b%b%b%b want data=%h zncv=%b%b%b%b",
                             res_data, flag_z, flag_n, flag_c, flag_v, e.d, e.z, e.n, e.c, e.v);
                end
            end
        end
    end

    // One clock; the adder model presents the previous cycle's operands' result.
    task automatic clk_step();
        @(posedge clk);
        #1;
        sum   = pend_sum;
        c_out = pend_c;
        start = 1'b0;
    endtask

    task automatic drive_issue(input logic a, input logic b, input logic [W-1:0] s, input logic c);
        res_t r;
        start    = 1'b1;
        a_msb    = a;
        b_msb    = b;
        pend_sum = s;
        pend_c   = c;
        if (q.size() >= 2) begin
            err_m = 1'b1;
        end else begin
            r.d = s;
            r.z = (s == '0);
            r.n = s[W-1];
            r.c = c;
            r.v = (a == b) && (s[W-1] != a);
            q.push_back(r);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        res_ready = 1'b1;
        a_msb     = 1'b1;
        b_msb     = 1'b1;
        sum       = '1;
        c_out     = 1'b1;
        repeat (3) begin
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if ({res_valid, busy, issue_err, res_data, flag_z, flag_n, flag_c, flag_v} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got valid=%b busy=%b err=%b data=%h zncv=%b%b%b%b want all 0",
                     res_valid, busy, issue_err, res_data, flag_z, flag_n, flag_c, flag_v);
        end
        start     = 1'b0;
        rst_n     = 1'b1;
        res_ready = 1'b0;
        q.delete();
        err_m = 1'b0;
        clk_step();
        n_vec++;
        if ({res_valid, busy, issue_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL after_reset got valid=%b busy=%b err=%b want 000", res_valid, busy, issue_err);
        end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        drive_issue(1'b0, 1'b0, 32'h0000_0005, 1'b0);
        clk_step();
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_cycle1 got valid=%b busy=%b want 0 0", res_valid, busy);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'd5 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_cycle2 got valid=%b data=%h zncv=%b%b%b%b want 1 5 0000",
                     res_valid, res_data, flag_z, flag_n, flag_c, flag_v);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drained got valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_flags();
        res_ready = 1'b1;
        drive_issue(1'b0, 1'b0, 32'h8000_0000, 1'b0);
        clk_step();
        drive_issue(1'b1, 1'b1, 32'h0000_0000, 1'b1);
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h8000_0000 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0101) begin
            n_bad++;
            $display("FAIL flags_pos_ovf got valid=%b data=%h zncv=%b%b%b%b want 1 80000000 0101",
                     res_valid, res_data, flag_z, flag_n, flag_c, flag_v);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b1011) begin
            n_bad++;
            $display("FAIL flags_neg_ovf got valid=%b data=%h zncv=%b%b%b%b want 1 00000000 1011",
                     res_valid, res_data, flag_z, flag_n, flag_c, flag_v);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flags_drained got valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        drive_issue(1'b0, 1'b0, 32'h0000_000A, 1'b0);
        clk_step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_credit got busy=%b want 0", busy);
        end
        drive_issue(1'b1, 1'b0, 32'h0000_000B, 1'b1);
        clk_step();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_busy got busy=%b want 1", busy);
        end
        drive_issue(1'b0, 1'b0, 32'h0000_000C, 1'b0);
        clk_step();
        n_vec++;
        if (issue_err !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_issue_err got %b want 1", issue_err);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_000A) begin
            n_bad++;
            $display("FAIL bp_head got valid=%b data=%h want 1 0000000a", res_valid, res_data);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_000A || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold got valid=%b data=%h busy=%b want 1 0000000a 1", res_valid, res_data, busy);
        end
        res_ready = 1'b1;
        n_pop = 0;
        repeat (4) clk_step();
        n_vec++;
        if (n_pop != 2 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_returned got %0d results valid=%b want 2 results valid=0", n_pop, res_valid);
        end
    endtask

    task automatic test_push_pop();
        res_ready = 1'b1;
        drive_issue(1'b0, 1'b0, 32'h0000_0011, 1'b0);
        clk_step();
        drive_issue(1'b0, 1'b1, 32'h0000_0022, 1'b1);
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0011) begin
            n_bad++;
            $display("FAIL pp_first got valid=%b data=%h want 1 00000011", res_valid, res_data);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0022 || flag_c !== 1'b1) begin
            n_bad++;
            $display("FAIL pp_advance got valid=%b data=%h c=%b want 1 00000022 1", res_valid, res_data, flag_c);
        end
        clk_step();
        n_vec++;
        if (res_valid !== 1'b0 || issue_err !== err_m) begin
            n_bad++;
            $display("FAIL pp_end got valid=%b err=%b want 0 %b", res_valid, issue_err, err_m);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        drive_issue(1'b0, 1'b0, 32'h0000_0033, 1'b0);
        clk_step();
        rst_n = 1'b0;
        clk_step();
        q.delete();
        err_m = 1'b0;
        rst_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || issue_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_after got busy=%b valid=%b err=%b want 000", busy, res_valid, issue_err);
        end
        for (int i = 0; i < 5; i++) begin
            clk_step();
            n_vec++;
            if (res_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rm_ghost cycle %0d got valid=%b want 0", i, res_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        int           waited;
        for (int i = 0; i < 60; i++) begin
            res_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                n_vec++;
                if (busy !== (q.size() >= 2)) begin
                    n_bad++;
                    $display("FAIL rnd_busy step %0d got %b want %b", i, busy, (q.size() >= 2));
                end
                s = $urandom();
                if ($urandom_range(0, 7) == 0) s = '0;
                drive_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)));
            end
            clk_step();
            n_vec++;
            if (issue_err !== err_m) begin
                n_bad++;
                $display("FAIL rnd_issue_err step %0d got %b want %b", i, issue_err, err_m);
            end
        end
        res_ready = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            clk_step();
            waited++;
        end
        n_vec++;
        if (q.size() != 0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_drain got %0d results outstanding valid=%b want 0 0", q.size(), res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
